// File: rtl/store_stage_pkg.sv
// Shared types for the store/writeback stage: op encoding, address and register-id widths,
// and the FSM state encoding.
package store_stage_pkg;

    localparam int unsigned PhysAddrWidth = 21;
    localparam int unsigned RegIdWidth    = 5;
    localparam int unsigned DataWidth     = 64;
    localparam int unsigned RetiredWidth  = 32;
    localparam int unsigned TimeoutWidth  = 16;

    typedef logic [PhysAddrWidth-1:0] phys_memory_address_t;
    typedef logic [RegIdWidth-1:0]    reg_id_t;

    typedef enum logic [1:0] {
        OpNop      = 2'd0,
        OpRegWrite = 2'd1,
        OpMemStore = 2'd2,
        OpJump     = 2'd3
    } store_op_t;

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StMemWait = 1'b1;

endpackage

// File: rtl/store_timeout_counter.sv
// Cycle counter for an outstanding memory write; expired is asserted combinationally on the
// last permitted wait cycle so the owner can give up at that clock edge.
module store_timeout_counter
    import store_stage_pkg::*;
#(
    parameter int unsigned Limit = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TimeoutWidth-1:0] LastCount = TimeoutWidth'(Limit - 1);

    logic [TimeoutWidth-1:0] count_q;
    logic [TimeoutWidth-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds wait cycles already elapsed, so this fires on the Limit-th one
    assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/store_stage.sv
// Writeback stage: retires execute results as register writes, fetch redirects or
// memory stores, waiting (with timeout) for the bus to acknowledge stores.
module store_stage
    import store_stage_pkg::*;
#(
    parameter int unsigned core_id     = 0,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [RegIdWidth-1:0]    in_reg_id,
    input  logic [DataWidth-1:0]     in_value,
    input  logic [PhysAddrWidth-1:0] in_address,
    output logic                     rf_we,
    output logic [RegIdWidth-1:0]    rf_id,
    output logic [DataWidth-1:0]     rf_data,
    output logic                     mem_req,
    output logic [PhysAddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0]     mem_wdata,
    input  logic                     mem_ack,
    output logic                     fetch_valid,
    output logic [PhysAddrWidth-1:0] fetch_pc,
    output logic [RetiredWidth-1:0]  retired,
    output logic                     mem_err
);

    logic [0:0]              state_q, state_d;
    logic                    rf_we_q, rf_we_d;
    reg_id_t                 rf_id_q, rf_id_d;
    logic [DataWidth-1:0]    rf_data_q, rf_data_d;
    logic                    mem_req_q, mem_req_d;
    phys_memory_address_t    mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    fetch_valid_q, fetch_valid_d;
    phys_memory_address_t    fetch_pc_q, fetch_pc_d;
    logic [RetiredWidth-1:0] retired_q, retired_d;
    logic                    mem_err_q, mem_err_d;

    store_op_t op;
    logic      accept;
    logic      retire;
    logic      waiting;
    logic      timeout_expired;

    assign op      = store_op_t'(in_op);
    assign waiting = (state_q == StMemWait);
    assign accept  = in_valid && !waiting;

    store_timeout_counter #(
        .Limit (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!waiting),
        .enable  (waiting && !mem_ack),
        .expired (timeout_expired)
    );

    always_comb begin
        state_d       = state_q;
        rf_we_d       = 1'b0;
        rf_id_d       = rf_id_q;
        rf_data_d     = rf_data_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        mem_err_d     = mem_err_q;
        retire        = 1'b0;

        if (!waiting) begin
            if (accept) begin
                unique case (op)
                    OpNop: begin
                        retire = 1'b1;
                    end
                    OpRegWrite: begin
                        rf_we_d   = 1'b1;
                        rf_id_d   = in_reg_id;
                        rf_data_d = in_value;
                        retire    = 1'b1;
                    end
                    OpMemStore: begin
                        state_d     = StMemWait;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = in_address;
                        mem_wdata_d = in_value;
                    end
                    OpJump: begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = in_address;
                        retire        = 1'b1;
                    end
                endcase
            end
        end else if (mem_ack) begin
            // an ack on the final allowed cycle still wins over the timeout
            state_d   = StIdle;
            mem_req_d = 1'b0;
            retire    = 1'b1;
        end else if (timeout_expired) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
            mem_err_d = 1'b1;
        end
    end

    assign retired_d = retired_q + RetiredWidth'(retire);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            rf_we_q       <= 1'b0;
            rf_id_q       <= '0;
            rf_data_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            retired_q     <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rf_we_q       <= rf_we_d;
            rf_id_q       <= rf_id_d;
            rf_data_q     <= rf_data_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            retired_q     <= retired_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign in_ready    = !waiting;
    assign rf_we       = rf_we_q;
    assign rf_id       = rf_id_q;
    assign rf_data     = rf_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign retired     = retired_q;
    assign mem_err     = mem_err_q;

    assert property (@(posedge clk) disable iff (!reset_n) !(mem_req && in_ready))
        else $error("store_stage core %0d: mem_req raised while accepting", core_id);

endmodule
